// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the display path.
// Counts are 10-bit; sync windows derive from visible + porch widths.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_H_TOTAL   =
        VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;
    localparam int unsigned VGA_V_TOTAL   =
        VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int unsigned VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_sync_gen.sv
// Registered VGA sync, active-video, coordinate and tick generation
// from the free-running h/v pixel counters.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned FCNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  h_count,
    input  logic [CNT_W-1:0]  v_count,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              line_tick,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_count
);

    localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_TOT = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_TOT = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_prev;
    logic [CNT_W-1:0] v_prev;

    logic in_range;
    logic visible;
    logic hs_win;
    logic vs_win;
    logic line_edge;
    logic frame_edge;

    // Out-of-range counts force every window and tick inactive.
    always_comb begin
        in_range   = (h_count < H_TOT) && (v_count < V_TOT);
        visible    = in_range && (h_count < H_VIS) && (v_count < V_VIS);
        hs_win     = in_range && (h_count >= HS_LO) && (h_count < HS_HI);
        vs_win     = in_range && (v_count >= VS_LO) && (v_count < VS_HI);
        line_edge  = in_range && (h_count == '0) && (h_prev != '0);
        frame_edge = in_range && (h_count == '0) && (v_count == '0)
                     && ((h_prev != '0) || (v_prev != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
            h_prev      <= '0;
            v_prev      <= '0;
        end else begin
            hsync       <= hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on    <= visible;
            pixel_x     <= visible ? h_count : '0;
            pixel_y     <= visible ? v_count : '0;
            line_tick   <= line_edge;
            frame_tick  <= frame_edge;
            frame_count <= frame_count + {{(FCNT_W-1){1'b0}}, frame_edge};
            h_prev      <= h_count;
            v_prev      <= v_count;
        end
    end

endmodule
